// File: rtl/tour_seq.sv
// tour_seq: top-level sequencer for the knight's-tour robot.
// Accepts a "start tour" command (opcode 4'h6) from the UART wrapper, starts
// the solver under a watchdog, launches the move-command sequencer and counts
// completed moves until the tour finishes, errors out or is aborted.
//
// Handshake note: the UART command is a level (cmd_rdy_UART held with
// cmd_UART) that stays pending until this block consumes it with a one-cycle
// clr_tour_cmd. Every other output pulse is a single registered cycle that
// follows the cycle in which its condition was sampled.
module tour_seq #(
  parameter int SOLVE_TIMEOUT = 50_000_000,
  parameter int NUM_MOVES     = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_tour_cmd,
  output logic        go,
  output logic [2:0]  x_start,
  output logic [2:0]  y_start,
  input  logic        solve_done,
  output logic        start_tour,
  input  logic        send_resp,
  input  logic        abort,
  output logic [4:0]  mv_cnt,
  output logic        tour_busy,
  output logic        tour_done,
  output logic        tour_err,
  output logic        err_resp,
  output logic [1:0]  dbg_state
);

  localparam int TW = $clog2(SOLVE_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(SOLVE_TIMEOUT - 1);
  localparam logic [4:0]    MOVES_LAST = 5'(NUM_MOVES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SOLVE  = 2'd1,
    S_LAUNCH = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t        r_state,  w_nxt_state;
  logic [TW-1:0] r_to_cnt, w_nxt_to_cnt;
  logic          r_leg,    w_nxt_leg;
  logic [2:0]    r_x,      w_nxt_x;
  logic [2:0]    r_y,      w_nxt_y;
  logic [4:0]    r_mv,     w_nxt_mv;
  logic          r_err,    w_nxt_err;
  logic          r_clr,    w_nxt_clr;
  logic          r_go,     w_nxt_go;
  logic          r_start,  w_nxt_start;
  logic          r_done,   w_nxt_done;
  logic          r_eresp,  w_nxt_eresp;
  logic          r_busy,   w_nxt_busy;

  logic w_tour_cmd;
  logic w_coord_ok;

  assign w_tour_cmd = cmd_rdy_UART && (cmd_UART[15:12] == 4'h6);
  assign w_coord_ok = (cmd_UART[6:4] <= 3'd4) && (cmd_UART[2:0] <= 3'd4);

  // Next-state and next-output decode; abort outranks every other transition.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_to_cnt = r_to_cnt;
    w_nxt_leg    = r_leg;
    w_nxt_x      = r_x;
    w_nxt_y      = r_y;
    w_nxt_mv     = r_mv;
    w_nxt_err    = r_err;
    w_nxt_clr    = 1'b0;
    w_nxt_go     = 1'b0;
    w_nxt_start  = 1'b0;
    w_nxt_done   = 1'b0;
    w_nxt_eresp  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A command waiting while abort is high stays pending.
        if (w_tour_cmd && !abort) begin
          w_nxt_clr = 1'b1;
          if (w_coord_ok) begin
            w_nxt_x      = cmd_UART[6:4];
            w_nxt_y      = cmd_UART[2:0];
            w_nxt_go     = 1'b1;
            w_nxt_err    = 1'b0;
            w_nxt_mv     = 5'd0;
            w_nxt_to_cnt = '0;
            w_nxt_state  = S_SOLVE;
          end else begin
            w_nxt_err   = 1'b1;
            w_nxt_eresp = 1'b1;
          end
        end
      end
      S_SOLVE: begin
        w_nxt_to_cnt = r_to_cnt + TW'(1);
        if (abort) begin
          w_nxt_state = S_IDLE;
        end else if (solve_done) begin
          w_nxt_state = S_LAUNCH;
        end else if (r_to_cnt == TO_LAST) begin
          w_nxt_state = S_IDLE;
          w_nxt_err   = 1'b1;
          w_nxt_eresp = 1'b1;
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_start = 1'b1;
          w_nxt_leg   = 1'b0;
          w_nxt_state = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_nxt_state = S_IDLE;
        end else if (send_resp) begin
          // Leg toggles vertical/horizontal; a move completes on the second leg.
          if (r_leg) begin
            w_nxt_leg = 1'b0;
            w_nxt_mv  = r_mv + 5'd1;
            if (r_mv == MOVES_LAST) begin
              w_nxt_done  = 1'b1;
              w_nxt_state = S_IDLE;
            end
          end else begin
            w_nxt_leg = 1'b1;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
    w_nxt_busy = (w_nxt_state != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_to_cnt <= '0;
      r_leg    <= 1'b0;
      r_x      <= 3'd0;
      r_y      <= 3'd0;
      r_mv     <= 5'd0;
      r_err    <= 1'b0;
      r_clr    <= 1'b0;
      r_go     <= 1'b0;
      r_start  <= 1'b0;
      r_done   <= 1'b0;
      r_eresp  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_to_cnt <= w_nxt_to_cnt;
      r_leg    <= w_nxt_leg;
      r_x      <= w_nxt_x;
      r_y      <= w_nxt_y;
      r_mv     <= w_nxt_mv;
      r_err    <= w_nxt_err;
      r_clr    <= w_nxt_clr;
      r_go     <= w_nxt_go;
      r_start  <= w_nxt_start;
      r_done   <= w_nxt_done;
      r_eresp  <= w_nxt_eresp;
      r_busy   <= w_nxt_busy;
    end
  end

  assign clr_tour_cmd = r_clr;
  assign go           = r_go;
  assign x_start      = r_x;
  assign y_start      = r_y;
  assign start_tour   = r_start;
  assign mv_cnt       = r_mv;
  assign tour_busy    = r_busy;
  assign tour_done    = r_done;
  assign tour_err     = r_err;
  assign err_resp     = r_eresp;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_tour_seq.sv
// Bench for tour_seq: directed scenarios plus a randomized phase, all checked
// cycle by cycle against a behavioural model of the sequencer.
module tb_tour_seq;

  localparam int TO = 100;
  localparam int NM = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd_UART = 16'h0000;
  logic        cmd_rdy_UART = 1'b0;
  logic        solve_done = 1'b0;
  logic        send_resp = 1'b0;
  logic        abort = 1'b0;
  logic        clr_tour_cmd, go, start_tour, tour_busy, tour_done, tour_err, err_resp;
  logic [2:0]  x_start, y_start;
  logic [4:0]  mv_cnt;
  logic [1:0]  dbg_state;

  tour_seq #(.SOLVE_TIMEOUT(TO), .NUM_MOVES(NM)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_tour_cmd(clr_tour_cmd), .go(go), .x_start(x_start), .y_start(y_start),
    .solve_done(solve_done), .start_tour(start_tour), .send_resp(send_resp),
    .abort(abort), .mv_cnt(mv_cnt), .tour_busy(tour_busy), .tour_done(tour_done),
    .tour_err(tour_err), .err_resp(err_resp), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int clr_seen = 0;
  always @(negedge clk) if (clr_tour_cmd) clr_seen++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 solving, 2 launching, 3 running
  int         m_phase = 0;
  int         m_age = 0;
  int         m_legs = 0;
  logic       e_clr = 0, e_go = 0, e_start = 0, e_done = 0, e_err = 0, e_eresp = 0;
  logic [2:0] e_x = 0, e_y = 0;
  logic [4:0] e_mv = 0;

  always @(posedge clk) begin
    e_clr = 0; e_go = 0; e_start = 0; e_done = 0; e_eresp = 0;
    if (!rst_n) begin
      m_phase = 0; m_age = 0; m_legs = 0;
      e_x = 0; e_y = 0; e_mv = 0; e_err = 0;
    end else begin
      case (m_phase)
        0: if (cmd_rdy_UART && cmd_UART[15:12] == 4'h6 && !abort) begin
             e_clr = 1;
             if (cmd_UART[6:4] <= 4 && cmd_UART[2:0] <= 4) begin
               e_go = 1; e_x = cmd_UART[6:4]; e_y = cmd_UART[2:0];
               e_mv = 0; e_err = 0; m_age = 0; m_phase = 1;
             end else begin
               e_err = 1; e_eresp = 1;
             end
           end
        1: begin
             m_age++;
             if (abort) m_phase = 0;
             else if (solve_done) m_phase = 2;
             else if (m_age == TO) begin m_phase = 0; e_err = 1; e_eresp = 1; end
           end
        2: if (abort) m_phase = 0;
           else begin e_start = 1; m_legs = 0; m_phase = 3; end
        default: if (abort) m_phase = 0;
           else if (send_resp) begin
             m_legs++;
             e_mv = 5'(m_legs / 2);
             if (m_legs == 2 * NM) begin e_done = 1; m_phase = 0; end
           end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  bit chk_en = 0;
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    exp_q.push_back({19'd0, e_clr, e_go, e_start, e_done, e_err, e_eresp, (m_phase != 0), e_mv});
    check("clr_tour_cmd", clr_tour_cmd, e_clr);
    check("go", go, e_go);
    check("x_start", x_start, e_x);
    check("y_start", y_start, e_y);
    check("start_tour", start_tour, e_start);
    check("mv_cnt", mv_cnt, e_mv);
    check("tour_busy", tour_busy, m_phase != 0);
    check("tour_done", tour_done, e_done);
    check("tour_err", tour_err, e_err);
    check("err_resp", err_resp, e_eresp);
    void'(exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a tour command and hold it until consumed (bounded).
  task automatic send_tour(input logic [15:0] c);
    bit seen = 0;
    cmd_UART = c;
    cmd_rdy_UART = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (clr_tour_cmd) seen = 1;
    end
    check("tour cmd consumed", seen, 1);
    cmd_rdy_UART = 1'b0;
  endtask

  task automatic pulse_resp(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_resp = 1'b1; tick(1); send_resp = 1'b0; tick(gap - 1);
    end
  endtask

  // Accept a command, let the solver finish quickly, end up in the run phase.
  task automatic launch_tour(input logic [15:0] c);
    send_tour(c);
    tick(2);
    solve_done = 1'b1; tick(1); solve_done = 1'b0;
    tick(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g, at, sd, c0;
    bit got;
    rst_n = 1'b0;
    @(negedge clk);
    chk_en = 1;
    tick(2);
    check("reset busy", tour_busy, 0);
    check("reset mv_cnt", mv_cnt, 0);
    rst_n = 1'b1;
    tick(2);

    // Basic accept and launch timing
    send_tour(16'h6023);
    check("go lit", go, 1);
    check("x_start lit", x_start, 2);
    check("y_start lit", y_start, 3);
    check("busy lit", tour_busy, 1);
    tick(9);
    solve_done = 1'b1; sd = cyc; tick(1); solve_done = 1'b0;
    got = 0; at = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (start_tour) begin got = 1; at = cyc; end
      else tick(1);
    end
    check("start_tour delay", got ? at - sd : 0, 2);

    // Full tour with an unrelated opcode pending throughout
    cmd_UART = 16'h2abc; cmd_rdy_UART = 1'b1; c0 = clr_seen;
    for (int p = 1; p <= 2 * NM; p++) begin
      send_resp = 1'b1; tick(1); send_resp = 1'b0;
      check("mv_cnt step", mv_cnt, p / 2);
      if (p == 2 * NM) check("tour_done lit", tour_done, 1);
      tick(4);
    end
    check("busy after tour", tour_busy, 0);
    pulse_resp(1, 3);
    check("mv_cnt hold 24", mv_cnt, 24);
    check("opcode2 not cleared", clr_seen - c0, 0);
    cmd_rdy_UART = 1'b0;
    tick(2);

    // Reset in the middle of a run
    launch_tour(16'h6044);
    pulse_resp(14, 2);
    check("mv_cnt 7", mv_cnt, 7);
    rst_n = 1'b0; tick(1);
    check("mid reset mv_cnt", mv_cnt, 0);
    check("mid reset busy", tour_busy, 0);
    check("mid reset start", start_tour, 0);
    rst_n = 1'b1; tick(2);

    // Invalid coordinates
    send_tour(16'h6051);
    check("bad x err_resp", err_resp, 1);
    check("bad x tour_err", tour_err, 1);
    check("bad x go", go, 0);
    check("bad x busy", tour_busy, 0);
    tick(3);
    send_tour(16'h6015);
    check("bad y err_resp", err_resp, 1);
    tick(3);

    // Solver timeout
    send_tour(16'h6000);
    check("err cleared", tour_err, 0);
    g = cyc; got = 0; at = 0;
    for (int i = 0; i < 150 && !got; i++) begin
      tick(1);
      if (err_resp) begin got = 1; at = cyc; end
    end
    check("timeout delay", got ? at - g : 0, TO);
    check("timeout tour_err", tour_err, 1);
    tick(3);

    // solve_done coinciding with the timeout wins
    send_tour(16'h6312);
    g = cyc;
    tick(TO - 1);
    solve_done = 1'b1; tick(1); solve_done = 1'b0;
    check("coincide no err_resp", err_resp, 0);
    check("coincide busy", tour_busy, 1);
    tick(1);
    check("coincide start", start_tour, 1);
    tick(1);

    // Abort together with the final leg
    cmd_UART = 16'h2001; cmd_rdy_UART = 1'b1; c0 = clr_seen;
    pulse_resp(2 * NM - 1, 3);
    send_resp = 1'b1; abort = 1'b1; tick(1); send_resp = 1'b0; abort = 1'b0;
    check("abort tour_done", tour_done, 0);
    check("abort mv_cnt", mv_cnt, NM - 1);
    check("abort busy", tour_busy, 0);
    check("opcode2 not cleared 2", clr_seen - c0, 0);
    cmd_rdy_UART = 1'b0;
    tick(2);

    // Abort in idle holds off a tour command
    cmd_UART = 16'h6011; cmd_rdy_UART = 1'b1; abort = 1'b1;
    tick(3);
    check("abort idle busy", tour_busy, 0);
    abort = 1'b0; tick(1);
    check("accept after abort", go, 1);
    cmd_rdy_UART = 1'b0; tick(2);
    abort = 1'b1; tick(1); abort = 1'b0;
    check("abort in solve", tour_busy, 0);
    tick(2);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      rst_n        = ($urandom_range(0, 599) != 0);
      cmd_rdy_UART = ($urandom_range(0, 7) == 0);
      cmd_UART     = {(($urandom_range(0, 3) == 0) ? 4'h6 : 4'($urandom_range(0, 15))),
                      12'($urandom_range(0, 4095))};
      solve_done   = ($urandom_range(0, 59) == 0);
      send_resp    = ($urandom_range(0, 1) == 0);
      abort        = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst_n = 1'b1; cmd_rdy_UART = 1'b0; solve_done = 1'b0; send_resp = 1'b0; abort = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
